// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-bus, redirect and decode-handshake signals of the
//            fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    modport master (
        output ireq_valid, ireq_addr, if_valid, if_pc, if_instr, if_misalign,
        input  iresp_valid, iresp_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, if_valid, if_pc, if_instr, if_misalign,
        output iresp_valid, iresp_data, redirect_valid, redirect_pc, if_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV64 instruction fetch: owns the PC, one outstanding bus request,
//            one-entry output register, discards fetches on redirect.
//            Optional macro FETCH_MISALIGN_CHK_EN: misaligned-PC marker.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int          PC_STEP  = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fetch_stage_if.master   fif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam logic [63:0] c_pc_step = 64'(PC_STEP);
    localparam logic [31:0] c_nop     = 32'h0000_0013;

    state_t      r_state,     w_state_nxt;
    logic [63:0] r_pc,        w_pc_nxt;
    logic [63:0] r_drop_addr, w_drop_addr_nxt;
    logic [63:0] r_if_pc,     w_if_pc_nxt;
    logic [31:0] r_if_instr,  w_if_instr_nxt;
    logic        r_if_valid,  w_if_valid_nxt;
    logic        r_if_mis,    w_if_mis_nxt;
    logic        w_misalign;

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= PC_RESET;
            r_drop_addr <= 64'd0;
            r_if_pc     <= 64'd0;
            r_if_instr  <= 32'd0;
            r_if_valid  <= 1'b0;
            r_if_mis    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
            r_if_pc     <= w_if_pc_nxt;
            r_if_instr  <= w_if_instr_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_if_mis    <= w_if_mis_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_if_pc_nxt     = r_if_pc;
        w_if_instr_nxt  = r_if_instr;
        w_if_valid_nxt  = r_if_valid;
        w_if_mis_nxt    = r_if_mis;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_misalign) begin
                    // No request was issued, so a redirect simply retargets.
                    if (fif.redirect_valid) begin
                        w_pc_nxt = fif.redirect_pc;
                    end else begin
                        w_if_valid_nxt = 1'b1;
                        w_if_mis_nxt   = 1'b1;
                        w_if_pc_nxt    = r_pc;
                        w_if_instr_nxt = c_nop;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (fif.redirect_valid && fif.iresp_valid) begin
                    w_pc_nxt = fif.redirect_pc;
                end else if (fif.redirect_valid) begin
                    // Keep presenting the abandoned address until its response.
                    w_drop_addr_nxt = r_pc;
                    w_pc_nxt        = fif.redirect_pc;
                    w_state_nxt     = S_DROP;
                end else if (fif.iresp_valid) begin
                    w_if_valid_nxt = 1'b1;
                    w_if_pc_nxt    = r_pc;
                    w_if_instr_nxt = fif.iresp_data;
                    w_pc_nxt       = r_pc + c_pc_step;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fif.redirect_valid || fif.if_ready) begin
                    w_if_valid_nxt = 1'b0;
                    w_if_mis_nxt   = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
                if (fif.redirect_valid) begin
                    w_pc_nxt = fif.redirect_pc;
                end
            end
            S_DROP: begin
                if (fif.iresp_valid) begin
                    w_state_nxt = S_FETCH;
                end
                if (fif.redirect_valid) begin
                    w_pc_nxt = fif.redirect_pc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign fif.ireq_valid  = ((r_state == S_FETCH) && !w_misalign) || (r_state == S_DROP);
    assign fif.ireq_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign fif.if_valid    = r_if_valid;
    assign fif.if_pc       = r_if_pc;
    assign fif.if_instr    = r_if_instr;
    assign fif.if_misalign = r_if_mis;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed vector table,
//            misaligned-PC sequence, randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    localparam logic [63:0] c_pc_reset = 64'h0000_0000_8000_0000;

    typedef struct {
        logic        rst;
        logic        rsp;
        logic [31:0] rdata;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_ifv;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    fetch_stage_if fif ();

    fetch_stage #(.PC_RESET(c_pc_reset), .PC_STEP(4)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: at most one pending request which is either live or
    // doomed, plus the single held output entry.
    logic        m_idle, m_fetch, m_dead, m_hv, m_hmis;
    logic [63:0] m_pc, m_daddr, m_hpc;
    logic [31:0] m_hinstr;

    function automatic logic m_misaligned();
`ifdef FETCH_MISALIGN_CHK_EN
        return (m_pc[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mk(logic rst, logic rsp, logic [31:0] rdata, logic rv,
                                logic [63:0] rpc, logic rdy, logic e_iv, logic [63:0] e_addr,
                                logic e_ifv, logic [63:0] e_pc, logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.rsp = rsp; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic rsp, input logic [31:0] rdata,
                         input logic rv, input logic [63:0] rpc, input logic rdy);
        reset              = rst;
        fif.iresp_valid    = rsp;
        fif.iresp_data     = rdata;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rpc;
        fif.if_ready       = rdy;
    endtask

    task automatic expect_outs(input string name, input logic e_iv, input logic [63:0] e_addr,
                               input logic e_ifv, input logic [63:0] e_pc,
                               input logic [31:0] e_instr, input logic e_mis);
        logic [162:0] act;
        logic [162:0] exp;
        act = {fif.ireq_valid, (fif.ireq_valid ? fif.ireq_addr : 64'd0), fif.if_valid,
               fif.if_pc, fif.if_instr, fif.if_misalign};
        exp = {e_iv, (e_iv ? e_addr : 64'd0), e_ifv, e_pc, e_instr, e_mis};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got iv=%b addr=%h ifv=%b pc=%h instr=%h mis=%b, expected iv=%b addr=%h ifv=%b pc=%h instr=%h mis=%b",
                     name, fif.ireq_valid, fif.ireq_addr, fif.if_valid, fif.if_pc, fif.if_instr,
                     fif.if_misalign, e_iv, e_addr, e_ifv, e_pc, e_instr, e_mis);
        end
    endtask

    task automatic model_step(input logic rst, input logic rsp, input logic [31:0] rdata,
                              input logic rv, input logic [63:0] rpc, input logic rdy);
        if (rst) begin
            m_idle = 1'b1; m_fetch = 1'b0; m_dead = 1'b0; m_hv = 1'b0; m_hmis = 1'b0;
            m_pc = c_pc_reset; m_daddr = 64'd0; m_hpc = 64'd0; m_hinstr = 32'd0;
        end else if (m_idle) begin
            m_idle  = 1'b0;
            m_fetch = 1'b1;
        end else if (m_fetch) begin
            if (m_misaligned()) begin
                if (rv) begin
                    m_pc = rpc;
                end else begin
                    m_hv = 1'b1; m_hmis = 1'b1; m_hpc = m_pc; m_hinstr = 32'h0000_0013;
                    m_fetch = 1'b0;
                end
            end else if (rsp && !rv) begin
                m_hv = 1'b1; m_hpc = m_pc; m_hinstr = rdata;
                m_pc = m_pc + 64'd4;
                m_fetch = 1'b0;
            end else if (rv) begin
                if (!rsp) begin
                    m_dead = 1'b1; m_daddr = m_pc; m_fetch = 1'b0;
                end
                m_pc = rpc;
            end
        end else if (m_dead) begin
            if (rsp) begin
                m_dead = 1'b0; m_fetch = 1'b1;
            end
            if (rv) m_pc = rpc;
        end else if (m_hv) begin
            if (rv || rdy) begin
                m_hv = 1'b0; m_hmis = 1'b0; m_fetch = 1'b1;
            end
            if (rv) m_pc = rpc;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);

        vecs.push_back(mk(1, 0, 32'h0, 0, 64'h0, 0,  0, 64'h0, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 0,  1, 64'h8000_0000, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h13, 0, 64'h0, 1, 0, 64'h0, 1, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 1,  1, 64'h8000_0004, 0, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 1, 32'h13, 0, 64'h0, 0, 0, 64'h0, 1, 64'h8000_0004, 32'h13));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 0, 0, 64'h0, 1, 64'h8000_0004, 32'h13));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 1,  1, 64'h8000_0008, 0, 64'h8000_0004, 32'h13));
        vecs.push_back(mk(0, 0, 32'h0, 1, 64'h8000_0100, 0, 1, 64'h8000_0008, 0, 64'h8000_0004, 32'h13));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 0,  1, 64'h8000_0008, 0, 64'h8000_0004, 32'h13));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 64'h0, 1, 1, 64'h8000_0100, 0, 64'h8000_0004, 32'h13));
        vecs.push_back(mk(0, 1, 32'h0010_0093, 1, 64'h8000_0200, 1, 1, 64'h8000_0200, 0, 64'h8000_0004, 32'h13));
        vecs.push_back(mk(0, 1, 32'h0020_0113, 0, 64'h0, 0, 0, 64'h0, 1, 64'h8000_0200, 32'h0020_0113));
        vecs.push_back(mk(0, 0, 32'h0, 1, 64'h8000_0300, 1, 1, 64'h8000_0300, 0, 64'h8000_0200, 32'h0020_0113));
        vecs.push_back(mk(0, 0, 32'h0, 1, 64'h8000_0400, 0, 1, 64'h8000_0300, 0, 64'h8000_0200, 32'h0020_0113));
        vecs.push_back(mk(1, 1, 32'h0BAD_F00D, 0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h0BAD_F00D, 0, 64'h0, 0, 1, 64'h8000_0000, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 0,  1, 64'h8000_0000, 0, 64'h0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h13, 0, 64'h0, 0, 0, 64'h0, 1, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 1,  1, 64'h8000_0004, 0, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 0, 32'h0, 1, 64'h8000_0500, 0, 1, 64'h8000_0004, 0, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 1, 32'hCAFE, 1, 64'h8000_0600, 0, 1, 64'h8000_0600, 0, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 1, 32'h77, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h8000_0000, 32'h13));
        vecs.push_back(mk(0, 1, 32'h0030_0193, 0, 64'h0, 0, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0193));
        vecs.push_back(mk(0, 0, 32'h0, 0, 64'h0, 1,  1, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0193));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rsp, vecs[i].rdata, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            @(negedge clk);
            expect_outs($sformatf("vec%0d", i), vecs[i].e_iv, vecs[i].e_addr, vecs[i].e_ifv,
                        vecs[i].e_pc, vecs[i].e_instr, 1'b0);
        end

        // Redirect to a misaligned target while fetching address 0.
        drive(1'b0, 1'b1, 32'h99, 1'b1, 64'h8000_0102, 1'b0);
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        expect_outs("mis_noreq", 0, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0193, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        expect_outs("mis_marker", 0, 64'h0, 1, 64'h8000_0102, 32'h0000_0013, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        expect_outs("mis_release", 0, 64'h0, 0, 64'h8000_0102, 32'h0000_0013, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0200, 1'b0);
        @(negedge clk);
        expect_outs("mis_redirect", 1, 64'h8000_0200, 0, 64'h8000_0102, 32'h0000_0013, 0);
`else
        expect_outs("mis_req", 1, 64'h8000_0102, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0193, 0);
        drive(1'b0, 1'b1, 32'h0000_0513, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        expect_outs("mis_fetched", 0, 64'h0, 1, 64'h8000_0102, 32'h0000_0513, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        expect_outs("mis_next", 1, 64'h8000_0106, 0, 64'h8000_0102, 32'h0000_0513, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_0200, 1'b0);
        @(negedge clk);
        expect_outs("mis_drop", 1, 64'h8000_0106, 0, 64'h8000_0102, 32'h0000_0513, 0);
`endif

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            logic        r_rst, r_rsp, r_rv, r_rdy;
            logic [31:0] r_data;
            logic [63:0] r_pc;
            if (k > 0)
                expect_outs($sformatf("rand%0d", k), (m_fetch && !m_misaligned()) || m_dead,
                            m_dead ? m_daddr : m_pc, m_hv, m_hpc, m_hinstr, m_hmis);
            r_rst  = (k == 0) || ($urandom_range(0, 99) == 0);
            r_rv   = ($urandom_range(0, 5) == 0);
            r_pc   = 64'h8000_0000 + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) r_pc = r_pc + 64'd2;
            r_rsp  = fif.ireq_valid && ($urandom_range(0, 2) != 0);
            r_data = $urandom;
            r_rdy  = ($urandom_range(0, 1) == 1);
            drive(r_rst, r_rsp, r_data, r_rv, r_pc, r_rdy);
            model_step(r_rst, r_rsp, r_data, r_rv, r_pc, r_rdy);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 64-bit RV pipeline. Sits directly upstream of decode/control: it produces the 32-bit instruction whose opcode field drives the control decoder.
- Owns the PC and issues one instruction-bus request at a time.
- Holds the fetched instruction in a one-entry output register under a valid/ready handshake.
- Discards in-flight fetches when the back end redirects the PC (branch, jal, jalr).

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset.
- PC_STEP, 4, byte increment of the sequential PC.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  64  request address; held stable while ireq_valid=1.
- iresp_valid  in  1  response for the outstanding request; same cycle as request or later.
- iresp_data  in  32  instruction word, valid when iresp_valid=1.
- redirect_valid  in  1  back end demands a PC change.
- redirect_pc  in  64  new PC target.
- if_valid  out  1  if_pc/if_instr hold a live instruction.
- if_ready  in  1  decode accepts the output this cycle.
- if_pc  out  64  PC of the held instruction.
- if_instr  out  32  held instruction.
- if_misalign  out  1  held entry is a misaligned-fetch marker (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: state=IDLE, pc=PC_RESET, ireq_valid=0, if_valid=0, if_pc=0, if_instr=0, if_misalign=0.
- Reset mid-transaction: the outstanding request is abandoned. Any later iresp_valid arriving while in IDLE is ignored.
- States: IDLE, FETCH, HOLD, DROP.
- ireq_valid=1 in FETCH and DROP only. ireq_addr=pc in FETCH; in DROP it is the latched address of the abandoned request.
- Handshake rule: once raised, ireq_valid and ireq_addr stay constant until the cycle iresp_valid=1.
- IDLE: always goes to FETCH the next cycle.
- FETCH:
  - redirect_valid=1 and iresp_valid=1 in the same cycle: drop the response, pc<=redirect_pc, stay in FETCH. The new request is visible next cycle.
  - redirect_valid=1, no response: latch drop address, pc<=redirect_pc, go to DROP.
  - iresp_valid=1, no redirect: if_instr<=iresp_data, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP (64-bit wrap, no carry-out), go to HOLD.
  - Neither: stay in FETCH.
- HOLD:
  - redirect_valid=1 has priority over if_ready: if_valid<=0, pc<=redirect_pc, go to FETCH.
  - Else if if_ready=1: if_valid<=0, go to FETCH.
  - Else: all outputs held bit-stable.
- DROP:
  - iresp_valid=1: discard the data, go to FETCH. If redirect_valid is also 1, pc<=redirect_pc.
  - redirect_valid=1 without a response: pc<=redirect_pc, stay in DROP. Only one transaction is ever outstanding.
- Latency and throughput:
  - Instruction appears on if_* the cycle after iresp_valid.
  - Peak throughput is 1 instruction per 2 cycles with a zero-wait bus.
  - No new request while if_valid=1.
- if_valid never asserts for a dropped response.
- if_ready while if_valid=0 is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Enabled: entering FETCH with pc[1:0]!=0 issues no bus request (ireq_valid=0). The next cycle loads if_valid=1, if_misalign=1, if_pc=pc, if_instr=32'h0000_0013, then goes to HOLD; pc is not advanced.
  - A redirect arriving in that FETCH cycle wins: pc<=redirect_pc, stay in FETCH, no marker is loaded.
  - if_misalign clears together with if_valid.
- Disabled: no alignment check; misaligned PCs are fetched normally; if_misalign constant 0.

Test Plan:
- Release reset, bus returns 32'h00000013 same cycle as request, if_ready=1 → ireq_addr=0x80000000, then 0x80000004. if_pc follows the same sequence, if_valid pulses every 2nd cycle.
- if_ready=0 for 5 cycles while holding pc 0x80000000 → if_pc/if_instr stable, ireq_valid=0 throughout. Release → next ireq_addr=0x80000004.
- Response delayed 3 cycles, redirect to 0x80000100 in wait cycle 1 → ireq_addr stays 0x80000000 until the response. Response dropped, if_valid never asserts for it, next ireq_addr=0x80000100.
- redirect_valid and iresp_valid in the same FETCH cycle, target 0x80000200 → response dropped, next ireq_addr=0x80000200.
- Assert reset while in DROP with a response pending → next cycle state IDLE, if_valid=0. Following request at 0x80000000, no stale instruction emitted.
- FETCH_MISALIGN_CHK_EN defined, redirect to 0x80000102 → no bus request, if_valid=1, if_misalign=1, if_pc=0x80000102, if_instr=0x00000013.
